// File: rtl/quad_frame_sched.sv
// rtl/quad_frame_sched.sv - periodic quadrature count sampler and framed delta serialiser
//
// Samples NUM_CH 8-bit decoder counts once every PERIOD clocks and sends the
// per-period deltas as one frame: HDR_BYTE, seq, delta[0..NUM_CH-1] and an
// optional checksum byte. The frame is sent over a valid/ready byte link.
// A tick that arrives while a frame is still in flight is dropped and sets
// the sticky overrun flag.
//
// Optional feature: define QUAD_FRAME_CSUM_EN to append a checksum byte
// (XOR of the seq byte and all delta bytes).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   enable    in   runs the tick prescaler; when low the prescaler is held at 0
//   counts    in   live decoder counts, channel k at [8k+7:8k]
//   tx_data   out  byte to the transmitter
//   tx_valid  out  tx_data is valid
//   tx_ready  in   transmitter takes the byte on tx_valid & tx_ready
//   busy      out  a frame is in flight
//   overrun   out  sticky: a tick arrived while busy
module quad_frame_sched #(
  parameter int         NUM_CH   = 2,
  parameter int         PERIOD   = 1000,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [8*NUM_CH-1:0] counts,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                overrun
);

  localparam int PW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SEQ,
    S_DATA,
    S_CSUM
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PW-1:0]   pre;
  logic            tick;
  logic [CW-1:0]   ch;
  logic            last_ch;
  logic            accept;
  logic [7:0]      seq;
  logic [7:0]      prev [NUM_CH];
  logic [7:0]      snap [NUM_CH];
`ifdef QUAD_FRAME_CSUM_EN
  logic [7:0]      csum;
`endif

  assign tick    = enable && (pre == PW'(PERIOD - 1));
  assign last_ch = (ch == CW'(NUM_CH - 1));
  assign accept  = tx_valid && tx_ready;
  assign busy    = (state != S_IDLE);

  // Tick prescaler: wraps PERIOD-1 -> 0; held at 0 while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (!enable || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      S_IDLE: begin
        if (tick) state_nxt = S_HDR;
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        if (tx_ready) state_nxt = S_SEQ;
      end
      S_SEQ: begin
        tx_valid = 1'b1;
        tx_data  = seq;
        if (tx_ready) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_data  = snap[ch];
        if (tx_ready && last_ch) begin
`ifdef QUAD_FRAME_CSUM_EN
          state_nxt = S_CSUM;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef QUAD_FRAME_CSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        if (tx_ready) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Snapshot, sequence, channel index and overrun bookkeeping. A tick on the
  // last-byte acceptance edge still sees state != IDLE, so it is an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq     <= 8'h00;
      ch      <= '0;
      overrun <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        prev[k] <= 8'h00;
        snap[k] <= 8'h00;
      end
    end else begin
      if (tick) begin
        if (state == S_IDLE) begin
          for (int k = 0; k < NUM_CH; k++) begin
            snap[k] <= counts[8*k +: 8] - prev[k];
            prev[k] <= counts[8*k +: 8];
          end
        end else begin
          overrun <= 1'b1;
        end
      end
      if (accept && state == S_SEQ) begin
        seq <= seq + 8'd1;
      end
      if (accept && state == S_DATA) begin
        ch <= last_ch ? '0 : ch + 1'b1;
      end
    end
  end

`ifdef QUAD_FRAME_CSUM_EN
  // Running XOR: seeded with the seq byte as it is accepted (before seq
  // increments), then folded with every accepted delta byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= 8'h00;
    end else if (accept && state == S_SEQ) begin
      csum <= seq;
    end else if (accept && state == S_DATA) begin
      csum <= csum ^ snap[ch];
    end
  end
`endif

endmodule

// File: tb/tb_quad_frame_sched.sv
// tb/tb_quad_frame_sched.sv - scoreboard bench for quad_frame_sched
module tb_quad_frame_sched;

  localparam int         NUM_CH = 2;
  localparam int         PERIOD = 16;
  localparam logic [7:0] HDR    = 8'hA5;

  logic                clk      = 1'b0;
  logic                rst_n    = 1'b0;
  logic                enable   = 1'b0;
  logic                tx_ready = 1'b0;
  logic [8*NUM_CH-1:0] counts   = '0;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                busy;
  logic                overrun;

  int vectors       = 0;
  int miscompares   = 0;
  int timeouts_req  = 0;
  int timeouts_seen = 0;

  logic [7:0] exp_q [$];
  int         m_pre = 0;
  logic [7:0] m_seq = 8'h00;
  logic       m_ovr = 1'b0;
  logic [7:0] m_prev [NUM_CH];

  quad_frame_sched #(
    .NUM_CH  (NUM_CH),
    .PERIOD  (PERIOD),
    .HDR_BYTE(HDR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .counts  (counts),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model. Runs on the falling edge: first compares
  // the outputs the DUT presents now, then applies the rules for the rising
  // edge to come using the (stable) inputs.
  always @(negedge clk) begin
    logic       busy_now;
    logic       tick;
    logic [7:0] d;
`ifdef QUAD_FRAME_CSUM_EN
    logic [7:0] cs;
`endif
    if (!rst_n) begin
      exp_q.delete();
      m_pre = 0;
      m_seq = 8'h00;
      m_ovr = 1'b0;
      for (int k = 0; k < NUM_CH; k++) m_prev[k] = 8'h00;
    end

    chk("tx_valid", {31'd0, tx_valid}, {31'd0, exp_q.size() != 0});
    chk("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
    chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    if (tx_valid && exp_q.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q[0]});
    if (!rst_n) chk("tx_data_rst", {24'd0, tx_data}, 32'd0);

    if (timeouts_seen < timeouts_req) begin
      timeouts_seen++;
      vectors++;
      miscompares++;
      $display("FAIL wait_timeout: got no expected tx_valid change at %0t", $time);
    end

    if (rst_n) begin
      busy_now = (exp_q.size() != 0);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_byte: got %0h expected none at %0t", tx_data, $time);
        end else begin
          void'(exp_q.pop_front());
        end
      end
      tick = 1'b0;
      if (enable) begin
        tick  = (m_pre == PERIOD - 1);
        m_pre = (m_pre + 1) % PERIOD;
      end else begin
        m_pre = 0;
      end
      if (tick) begin
        if (busy_now) begin
          m_ovr = 1'b1;
        end else begin
          exp_q.push_back(HDR);
          exp_q.push_back(m_seq);
`ifdef QUAD_FRAME_CSUM_EN
          cs = m_seq;
`endif
          for (int k = 0; k < NUM_CH; k++) begin
            d = counts[8*k +: 8] - m_prev[k];
            m_prev[k] = counts[8*k +: 8];
            exp_q.push_back(d);
`ifdef QUAD_FRAME_CSUM_EN
            cs = cs ^ d;
`endif
          end
`ifdef QUAD_FRAME_CSUM_EN
          exp_q.push_back(cs);
`endif
          m_seq = m_seq + 8'd1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input logic level);
    int n = 0;
    while (tx_valid !== level && n < 200) begin
      cyc(1);
      n++;
    end
    if (tx_valid !== level) timeouts_req++;
  endtask

  initial begin
    cyc(3);
    // First frame: A5,00,03,05
    rst_n    = 1'b1;
    enable   = 1'b1;
    counts   = {8'h05, 8'h03};
    tx_ready = 1'b1;
    cyc(20);
    // Wrapping deltas: A5,01,FB,FF
    counts = {8'h04, 8'hFE};
    cyc(16);
    // Stall after HDR across a tick
    wait_valid(1'b1);
    cyc(1);
    tx_ready = 1'b0;
    counts   = {8'h20, 8'h10};
    cyc(20);
    tx_ready = 1'b1;
    cyc(24);
    // tx_ready toggling every cycle
    for (int i = 0; i < 80; i++) begin
      tx_ready = ~tx_ready;
      if (i % 5 == 0) counts = 16'($urandom);
      cyc(1);
    end
    // Random ready and counts
    for (int i = 0; i < 300; i++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      counts   = 16'($urandom);
      cyc(1);
    end
    // Reset during a DATA byte
    tx_ready = 1'b1;
    wait_valid(1'b0);
    tx_ready = 1'b0;
    wait_valid(1'b1);
    tx_ready = 1'b1;
    cyc(2);
    tx_ready = 1'b0;
    rst_n    = 1'b0;
    cyc(3);
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    counts   = 16'($urandom);
    cyc(40);
    // Disable mid-frame: frame completes, then silence
    tx_ready = 1'b0;
    wait_valid(1'b1);
    enable   = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 3 * PERIOD + 10; i++) begin
      counts = 16'($urandom);
      cyc(1);
    end
    enable = 1'b1;
    cyc(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
